// File: rtl/tl_track_pkg.sv
// Shared types and helpers for the TileLink transaction tracker.
// Entry states, error bit positions and burst-length decode live here.
package tl_track_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQ,
    ST_WAIT_GNT,
    ST_GNT,
    ST_WAIT_FIN
  } entry_state_e;

  localparam int ERR_W           = 6;
  localparam int ERR_OVERFLOW    = 0;
  localparam int ERR_DUP_ID      = 1;
  localparam int ERR_GNT_NOMATCH = 2;
  localparam int ERR_FIN_NOMATCH = 3;
  localparam int ERR_BEAT_ORDER  = 4;
  localparam int ERR_TIMEOUT     = 5;

  localparam logic [2:0] A_PUT_BLOCK      = 3'd3;
  localparam logic [3:0] G_GET_DATA_BLOCK = 4'd4;

  function automatic logic acq_multibeat(input logic builtin, input logic [2:0] a_type);
    return builtin && (a_type == A_PUT_BLOCK);
  endfunction

  function automatic logic gnt_multibeat(input logic builtin, input logic [3:0] g_type);
    return builtin ? (g_type == G_GET_DATA_BLOCK) : 1'b1;
  endfunction

endpackage

// File: rtl/tl_track_entry.sv
// One tracker table slot: lifecycle FSM, stored request fields and CAM compares.
// state | meaning
// IDLE     | slot free
// ACQ      | multi-beat acquire still streaming in
// WAIT_GNT | acquire complete, waiting for first grant beat
// GNT      | multi-beat grant streaming
// WAIT_FIN | coherent grant done, waiting for finish
module tl_track_entry
  import tl_track_pkg::*;
#(
  parameter int CLIENT_ID_W = 2,
  parameter int XACT_ID_W   = 5,
  parameter int MGR_XACT_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc,
  input  logic                   alloc_burst,
  input  logic [CLIENT_ID_W-1:0] alloc_client_id,
  input  logic [XACT_ID_W-1:0]   alloc_xact_id,
  input  logic                   alloc_builtin,
  input  logic [2:0]             alloc_a_type,
  input  logic                   acq_close,
  input  logic                   gnt_hit,
  input  logic                   gnt_last,
  input  logic                   gnt_builtin,
  input  logic [MGR_XACT_W-1:0]  gnt_mgr_xact_id,
  input  logic                   fin_hit,
  input  logic [CLIENT_ID_W-1:0] cmp_acq_client_id,
  input  logic [XACT_ID_W-1:0]   cmp_acq_xact_id,
  input  logic [CLIENT_ID_W-1:0] cmp_gnt_client_id,
  input  logic [XACT_ID_W-1:0]   cmp_gnt_xact_id,
  input  logic [MGR_XACT_W-1:0]  cmp_fin_mgr_xact_id,
  output logic                   busy,
  output logic                   acq_id_match,
  output logic                   gnt_match,
  output logic                   fin_match,
  output logic                   free_now
);

  entry_state_e           state_q, state_d;
  logic [CLIENT_ID_W-1:0] client_id_q, client_id_d;
  logic [XACT_ID_W-1:0]   xact_id_q, xact_id_d;
  logic                   builtin_q, builtin_d;
  logic [2:0]             a_type_q, a_type_d;
  logic [MGR_XACT_W-1:0]  mgr_xact_id_q, mgr_xact_id_d;

  assign busy         = (state_q != ST_IDLE);
  assign acq_id_match = busy && (client_id_q == cmp_acq_client_id) && (xact_id_q == cmp_acq_xact_id);
  assign gnt_match    = ((state_q == ST_WAIT_GNT) || (state_q == ST_GNT)) &&
                        (client_id_q == cmp_gnt_client_id) && (xact_id_q == cmp_gnt_xact_id);
  assign fin_match    = (state_q == ST_WAIT_FIN) && (mgr_xact_id_q == cmp_fin_mgr_xact_id);

  always_comb begin
    state_d       = state_q;
    client_id_d   = client_id_q;
    xact_id_d     = xact_id_q;
    builtin_d     = builtin_q;
    a_type_d      = a_type_q;
    mgr_xact_id_d = mgr_xact_id_q;
    free_now      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (alloc) begin
          client_id_d = alloc_client_id;
          xact_id_d   = alloc_xact_id;
          builtin_d   = alloc_builtin;
          a_type_d    = alloc_a_type;
          state_d     = alloc_burst ? ST_ACQ : ST_WAIT_GNT;
        end
      end
      ST_ACQ: begin
        if (acq_close && acq_multibeat(builtin_q, a_type_q)) state_d = ST_WAIT_GNT;
      end
      ST_WAIT_GNT, ST_GNT: begin
        if (gnt_hit) begin
          mgr_xact_id_d = gnt_mgr_xact_id;
          if (!gnt_last) begin
            state_d = ST_GNT;
          end else if (gnt_builtin) begin
            state_d  = ST_IDLE;
            free_now = 1'b1;
          end else begin
            state_d = ST_WAIT_FIN;
          end
        end
      end
      ST_WAIT_FIN: begin
        if (fin_hit) begin
          state_d  = ST_IDLE;
          free_now = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      client_id_q   <= '0;
      xact_id_q     <= '0;
      builtin_q     <= 1'b0;
      a_type_q      <= '0;
      mgr_xact_id_q <= '0;
    end else begin
      state_q       <= state_d;
      client_id_q   <= client_id_d;
      xact_id_q     <= xact_id_d;
      builtin_q     <= builtin_d;
      a_type_q      <= a_type_d;
      mgr_xact_id_q <= mgr_xact_id_d;
    end
  end

endmodule

// File: rtl/tilelink_xact_tracker.sv
// Passive TileLink acquire/grant/finish monitor: tracks each acquire in a table,
// counts traffic, latches sticky protocol errors and runs a stall watchdog.
module tilelink_xact_tracker
  import tl_track_pkg::*;
#(
  parameter int CLIENT_ID_W = 2,
  parameter int XACT_ID_W   = 5,
  parameter int MGR_XACT_W  = 4,
  parameter int BEAT_W      = 2,
  parameter int NUM_XACT    = 8,
  parameter int TIMEOUT     = 4096,
  parameter int CNT_W       = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           acq_valid,
  input  logic                           acq_ready,
  input  logic [CLIENT_ID_W-1:0]         acq_client_id,
  input  logic [XACT_ID_W-1:0]           acq_client_xact_id,
  input  logic [BEAT_W-1:0]              acq_addr_beat,
  input  logic                           acq_is_builtin,
  input  logic [2:0]                     acq_a_type,
  input  logic                           gnt_valid,
  input  logic                           gnt_ready,
  input  logic [CLIENT_ID_W-1:0]         gnt_client_id,
  input  logic [XACT_ID_W-1:0]           gnt_client_xact_id,
  input  logic [MGR_XACT_W-1:0]          gnt_mgr_xact_id,
  input  logic [BEAT_W-1:0]              gnt_addr_beat,
  input  logic                           gnt_is_builtin,
  input  logic [3:0]                     gnt_g_type,
  input  logic                           fin_valid,
  input  logic                           fin_ready,
  input  logic [MGR_XACT_W-1:0]          fin_mgr_xact_id,
  input  logic                           rel_valid,
  input  logic                           rel_ready,
  input  logic                           rel_voluntary,
  output logic [CNT_W-1:0]               cnt_acquire,
  output logic [CNT_W-1:0]               cnt_grant,
  output logic [CNT_W-1:0]               cnt_finish,
  output logic [CNT_W-1:0]               cnt_vol_release,
  output logic [$clog2(NUM_XACT+1)-1:0]  outstanding,
  output logic [ERR_W-1:0]               err_flags,
  output logic [2:0]                     first_err
);

  localparam int OUT_W = $clog2(NUM_XACT + 1);
  localparam int IDX_W = (NUM_XACT > 1) ? $clog2(NUM_XACT) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = '1;
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_XACT-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_XACT - 1; i >= 0; i--) if (v[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  logic acq_fire, gnt_fire, fin_fire, rel_fire;
  assign acq_fire = acq_valid & acq_ready;
  assign gnt_fire = gnt_valid & gnt_ready;
  assign fin_fire = fin_valid & fin_ready;
  assign rel_fire = rel_valid & rel_ready;

  logic [NUM_XACT-1:0] busy, acq_id_match, gnt_match, fin_match, free_now;
  logic [NUM_XACT-1:0] alloc_vec, acq_close_vec, gnt_hit_vec, fin_hit_vec;

  logic              acq_open_q, acq_open_d, acq_hit_q, acq_hit_d;
  logic [IDX_W-1:0]  acq_idx_q, acq_idx_d;
  logic [BEAT_W-1:0] acq_exp_q, acq_exp_d;
  logic              gnt_open_q, gnt_open_d, gnt_hit_q, gnt_hit_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [BEAT_W-1:0] gnt_exp_q, gnt_exp_d;

  logic [CNT_W-1:0]  cnt_acquire_q, cnt_acquire_d, cnt_grant_q, cnt_grant_d;
  logic [CNT_W-1:0]  cnt_finish_q, cnt_finish_d, cnt_vol_release_q, cnt_vol_release_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d, free_cnt;
  logic [15:0]       wd_q, wd_d;
  logic [ERR_W-1:0]  err_flags_q, err_flags_d, err_new;
  logic [2:0]        first_err_q, first_err_d;

  // First beat of an acquire/grant is the one seen while no burst of that channel is open.
  logic             acq_first, acq_cont, acq_mb, acq_last_beat, alloc_found, alloc_burst;
  logic [IDX_W-1:0] alloc_idx;
  logic             gnt_first, gnt_cont, gnt_vol, gnt_mb, gnt_last_beat, gnt_last, gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic             fin_found;

  assign acq_first     = acq_fire & ~acq_open_q;
  assign acq_cont      = acq_fire & acq_open_q;
  assign acq_mb        = acq_multibeat(acq_is_builtin, acq_a_type);
  assign acq_last_beat = (acq_addr_beat == LAST_BEAT);
  assign alloc_found   = ~&busy;
  assign alloc_idx     = lowest(~busy);
  assign alloc_burst   = acq_mb & ~acq_last_beat;

  assign gnt_first     = gnt_fire & ~gnt_open_q;
  assign gnt_cont      = gnt_fire & gnt_open_q;
  assign gnt_vol       = gnt_is_builtin && (gnt_g_type == 4'd0);
  assign gnt_mb        = gnt_multibeat(gnt_is_builtin, gnt_g_type);
  assign gnt_last_beat = (gnt_addr_beat == LAST_BEAT);
  assign gnt_last      = (gnt_first && !gnt_mb) ? 1'b1 : gnt_last_beat;
  assign gnt_found     = |gnt_match;
  assign gnt_idx       = lowest(gnt_match);
  assign fin_found     = |fin_match;

  always_comb begin
    for (int i = 0; i < NUM_XACT; i++) begin
      alloc_vec[i]     = acq_first && alloc_found && (alloc_idx == IDX_W'(i));
      acq_close_vec[i] = acq_cont && acq_last_beat && acq_hit_q && (acq_idx_q == IDX_W'(i));
      gnt_hit_vec[i]   = (gnt_first && !gnt_vol && gnt_found && (gnt_idx == IDX_W'(i))) ||
                         (gnt_cont && gnt_hit_q && (gnt_idx_q == IDX_W'(i)));
      fin_hit_vec[i]   = fin_fire && fin_found && (lowest(fin_match) == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_XACT; g++) begin : g_entry
    tl_track_entry #(
      .CLIENT_ID_W(CLIENT_ID_W),
      .XACT_ID_W  (XACT_ID_W),
      .MGR_XACT_W (MGR_XACT_W)
    ) u_entry (
      .clk                (clk),
      .reset              (reset),
      .alloc              (alloc_vec[g]),
      .alloc_burst        (alloc_burst),
      .alloc_client_id    (acq_client_id),
      .alloc_xact_id      (acq_client_xact_id),
      .alloc_builtin      (acq_is_builtin),
      .alloc_a_type       (acq_a_type),
      .acq_close          (acq_close_vec[g]),
      .gnt_hit            (gnt_hit_vec[g]),
      .gnt_last           (gnt_last),
      .gnt_builtin        (gnt_is_builtin),
      .gnt_mgr_xact_id    (gnt_mgr_xact_id),
      .fin_hit            (fin_hit_vec[g]),
      .cmp_acq_client_id  (acq_client_id),
      .cmp_acq_xact_id    (acq_client_xact_id),
      .cmp_gnt_client_id  (gnt_client_id),
      .cmp_gnt_xact_id    (gnt_client_xact_id),
      .cmp_fin_mgr_xact_id(fin_mgr_xact_id),
      .busy               (busy[g]),
      .acq_id_match       (acq_id_match[g]),
      .gnt_match          (gnt_match[g]),
      .fin_match          (fin_match[g]),
      .free_now           (free_now[g])
    );
  end

  always_comb begin
    acq_open_d = acq_open_q;
    acq_hit_d  = acq_hit_q;
    acq_idx_d  = acq_idx_q;
    acq_exp_d  = acq_exp_q;
    if (acq_first && alloc_burst) begin
      acq_open_d = 1'b1;
      acq_hit_d  = alloc_found;
      acq_idx_d  = alloc_idx;
      acq_exp_d  = acq_addr_beat + BEAT_W'(1);
    end else if (acq_cont) begin
      acq_open_d = ~acq_last_beat;
      acq_exp_d  = acq_addr_beat + BEAT_W'(1);
    end

    gnt_open_d = gnt_open_q;
    gnt_hit_d  = gnt_hit_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_exp_d  = gnt_exp_q;
    if (gnt_first && !gnt_vol && !gnt_last) begin
      gnt_open_d = 1'b1;
      gnt_hit_d  = gnt_found;
      gnt_idx_d  = gnt_idx;
      gnt_exp_d  = gnt_addr_beat + BEAT_W'(1);
    end else if (gnt_cont) begin
      gnt_open_d = ~gnt_last_beat;
      gnt_exp_d  = gnt_addr_beat + BEAT_W'(1);
    end
  end

  always_comb begin
    err_new = '0;
    err_new[ERR_OVERFLOW]    = acq_first && !alloc_found;
    err_new[ERR_DUP_ID]      = acq_first && (|acq_id_match);
    err_new[ERR_GNT_NOMATCH] = gnt_first && !gnt_vol && !gnt_found;
    err_new[ERR_FIN_NOMATCH] = fin_fire && !fin_found;
    err_new[ERR_BEAT_ORDER]  = (acq_first && acq_mb && (acq_addr_beat != '0)) ||
                               (acq_cont && (acq_addr_beat != acq_exp_q)) ||
                               (gnt_first && !gnt_vol && gnt_mb && (gnt_addr_beat != '0)) ||
                               (gnt_cont && (gnt_addr_beat != gnt_exp_q));

    // Watchdog only runs while something is outstanding and the bus is quiet.
    if (acq_fire || gnt_fire || fin_fire || (outstanding_q == '0)) wd_d = '0;
    else if (wd_q == WD_LIMIT) wd_d = wd_q;
    else wd_d = wd_q + 16'd1;
    err_new[ERR_TIMEOUT] = (wd_d == WD_LIMIT);

    err_flags_d = err_flags_q | err_new;
    first_err_d = first_err_q;
    if (first_err_q == 3'd0) begin
      for (int i = ERR_W - 1; i >= 0; i--) if (err_new[i]) first_err_d = 3'(i + 1);
    end

    free_cnt = '0;
    for (int i = 0; i < NUM_XACT; i++) free_cnt = free_cnt + OUT_W'(free_now[i]);
    outstanding_d = outstanding_q + OUT_W'(|alloc_vec) - free_cnt;

    cnt_acquire_d     = (acq_first && cnt_acquire_q != '1) ? cnt_acquire_q + CNT_W'(1) : cnt_acquire_q;
    cnt_grant_d       = (gnt_first && cnt_grant_q != '1) ? cnt_grant_q + CNT_W'(1) : cnt_grant_q;
    cnt_finish_d      = (fin_fire && cnt_finish_q != '1) ? cnt_finish_q + CNT_W'(1) : cnt_finish_q;
    cnt_vol_release_d = (rel_fire && rel_voluntary && cnt_vol_release_q != '1) ?
                        cnt_vol_release_q + CNT_W'(1) : cnt_vol_release_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acq_open_q        <= 1'b0;
      acq_hit_q         <= 1'b0;
      acq_idx_q         <= '0;
      acq_exp_q         <= '0;
      gnt_open_q        <= 1'b0;
      gnt_hit_q         <= 1'b0;
      gnt_idx_q         <= '0;
      gnt_exp_q         <= '0;
      cnt_acquire_q     <= '0;
      cnt_grant_q       <= '0;
      cnt_finish_q      <= '0;
      cnt_vol_release_q <= '0;
      outstanding_q     <= '0;
      wd_q              <= '0;
      err_flags_q       <= '0;
      first_err_q       <= '0;
    end else begin
      acq_open_q        <= acq_open_d;
      acq_hit_q         <= acq_hit_d;
      acq_idx_q         <= acq_idx_d;
      acq_exp_q         <= acq_exp_d;
      gnt_open_q        <= gnt_open_d;
      gnt_hit_q         <= gnt_hit_d;
      gnt_idx_q         <= gnt_idx_d;
      gnt_exp_q         <= gnt_exp_d;
      cnt_acquire_q     <= cnt_acquire_d;
      cnt_grant_q       <= cnt_grant_d;
      cnt_finish_q      <= cnt_finish_d;
      cnt_vol_release_q <= cnt_vol_release_d;
      outstanding_q     <= outstanding_d;
      wd_q              <= wd_d;
      err_flags_q       <= err_flags_d;
      first_err_q       <= first_err_d;
    end
  end

  assign cnt_acquire     = cnt_acquire_q;
  assign cnt_grant       = cnt_grant_q;
  assign cnt_finish      = cnt_finish_q;
  assign cnt_vol_release = cnt_vol_release_q;
  assign outstanding     = outstanding_q;
  assign err_flags       = err_flags_q;
  assign first_err       = first_err_q;

endmodule
